dmux_hs_tx: RTL and testbench

//  Source-side transmitter for the DMUX clock-domain-crossing path. It accepts a word

---
 rtl/dmux_hs_tx.sv | 120 ++++++++++++
 tb/tb_dmux_hs_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_hs_tx.sv
// dmux_hs_tx
//   Source-side transmitter of the DMUX clock-domain-crossing path. A word taken
//   under src_vld/src_rdy is launched as a toggle on req_a, with data_a held stable
//   until the clk_b receiver returns a matching toggle on ack_b. That toggle is
//   double-synchronised here before the next word is accepted. If no acknowledge
//   arrives within TIMEOUT cycles, a sticky error is raised.
//
// Ports
//   gated_clka   in   1      source clock (clock-gated clk_a)
//   rst_n_b      in   1      reset, asynchronous, active-high
//   src_vld      in   1      upstream word valid
//   src_rdy      out  1      block can accept a word (combinational from state)
//   src_data     in   WIDTH  upstream word
//   ack_b        in   1      toggle acknowledge from clk_b (asynchronous here)
//   req_a        out  1      toggle request to clk_b (flop output)
//   data_a       out  WIDTH  launched word, stable while busy
//   busy         out  1      transfer outstanding
//   xfer_done    out  1      one-cycle pulse when the current word is acknowledged
//   timeout_err  out  1      sticky lost-acknowledge flag
//   err_clr      in   1      clears timeout_err, and leaves ERR for IDLE
module dmux_hs_tx #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255,
   parameter int CNT_W       = 8
) (
   input  logic             gated_clka,
   input  logic             rst_n_b,
   input  logic             src_vld,
   output logic             src_rdy,
   input  logic [WIDTH-1:0] src_data,
   input  logic             ack_b,
   output logic             req_a,
   output logic [WIDTH-1:0] data_a,
   output logic             busy,
   output logic             xfer_done,
   output logic             timeout_err,
   input  logic             err_clr
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, ERR} state_t;

   localparam bit              TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic                   ack_d;
   logic                   ack_edge;
   logic [CNT_W-1:0]       cnt;

   assign src_rdy  = (state == IDLE);
   assign ack_s    = ack_sync[SYNC_STAGES-1];
   // Any change of the synchronised ack level counts as one acknowledge.
   assign ack_edge = ack_s ^ ack_d;

   always_ff @(posedge gated_clka or posedge rst_n_b) begin
      if (rst_n_b) begin
         ack_sync <= '0;
         ack_d    <= 1'b0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_b};
         ack_d    <= ack_s;
      end
   end

   always_ff @(posedge gated_clka or posedge rst_n_b) begin
      if (rst_n_b) begin
         state       <= IDLE;
         req_a       <= 1'b0;
         data_a      <= '0;
         busy        <= 1'b0;
         xfer_done   <= 1'b0;
         timeout_err <= 1'b0;
         cnt         <= '0;
      end else begin
         xfer_done <= 1'b0;
         if (err_clr) timeout_err <= 1'b0;
         case (state)
            // An ack_edge seen here is stale and is dropped.
            IDLE: begin
               if (src_vld) begin
                  data_a <= src_data;
                  req_a  <= ~req_a;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= WAIT_ACK;
               end
            end
            // An ack beats a timeout that falls in the same cycle.
            WAIT_ACK: begin
               if (ack_edge) begin
                  xfer_done <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (TO_EN && cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= ERR;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            // req_a is left as is, so the next launch toggles it normally.
            ERR: begin
               if (err_clr) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmux_hs_tx.sv
// tb_dmux_hs_tx
//   Scoreboard bench for dmux_hs_tx (TIMEOUT=8). Launched words are queued when
//   they are driven. A negedge monitor pops them on every req_a toggle and every
//   xfer_done pulse, and checks data_a against the queued word.
module tb_dmux_hs_tx;

   logic        gated_clka = 1'b0;
   logic        rst_n_b    = 1'b1;
   logic        src_vld    = 1'b0;
   logic        src_rdy;
   logic [31:0] src_data   = '0;
   logic        ack_b      = 1'b0;
   logic        req_a;
   logic [31:0] data_a;
   logic        busy;
   logic        xfer_done;
   logic        timeout_err;
   logic        err_clr    = 1'b0;

   dmux_hs_tx #(.WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(8), .CNT_W(8)) dut (
      .gated_clka (gated_clka),
      .rst_n_b    (rst_n_b),
      .src_vld    (src_vld),
      .src_rdy    (src_rdy),
      .src_data   (src_data),
      .ack_b      (ack_b),
      .req_a      (req_a),
      .data_a     (data_a),
      .busy       (busy),
      .xfer_done  (xfer_done),
      .timeout_err(timeout_err),
      .err_clr    (err_clr)
   );

   always #5 gated_clka = ~gated_clka;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] launch_q[$];
   logic [31:0] done_q[$];
   int          n_tog = 0;
   int          n_done = 0;
   logic        prev_req = 1'b0;
   bit          ack_auto = 1'b0;
   logic        ack_tgt = 1'b0;
   int          dly = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // All bench-side stimulus acts 1 time unit after the falling edge, after the monitor.
   task automatic nxt();
      @(negedge gated_clka);
      #1;
   endtask

   // Monitor: scoreboard pops on launch and on completion.
   always @(negedge gated_clka) begin
      if (rst_n_b) begin
         prev_req = 1'b0;
      end else begin
         if (req_a !== prev_req) begin
            prev_req = req_a;
            n_tog++;
            chk("launch_q_size", launch_q.size(), 1);
            if (launch_q.size() != 0) chk("launch_data", data_a, launch_q.pop_front());
         end
         if (xfer_done) begin
            n_done++;
            chk("done_q_size", done_q.size(), 1);
            if (done_q.size() != 0) chk("done_data", data_a, done_q.pop_front());
         end
      end
   end

   // Receiver model: echoes req_a onto ack_b a fixed number of cycles after it toggles.
   always @(negedge gated_clka) begin
      if (ack_auto && !rst_n_b) begin
         if (req_a !== ack_tgt) begin
            ack_tgt = req_a;
            dly     = 1;
         end else if (dly != 0) begin
            dly++;
            if (dly == 5) begin
               ack_b = ack_tgt;
               dly   = 0;
            end
         end
      end
   end

   task automatic send(input logic [31:0] w);
      src_vld  = 1'b1;
      src_data = w;
      for (int i = 0; i < 60 && !src_rdy; i++) nxt();
      chk("send_rdy", src_rdy, 1);
      if (src_rdy) begin
         launch_q.push_back(w);
         done_q.push_back(w);
      end
      nxt();
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && done_q.size() != 0; i++) nxt();
      chk("drain", done_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int d0;
      int tk;
      bit seen;

      // T1: ack_b toggling while reset is held
      rst_n_b = 1'b1;
      repeat (3) begin nxt(); ack_b = ~ack_b; end
      nxt();
      chk("t1_req", req_a, 0);
      chk("t1_data", data_a, 0);
      chk("t1_rdy", src_rdy, 1);
      chk("t1_busy", busy, 0);
      chk("t1_done", xfer_done, 0);
      chk("t1_err", timeout_err, 0);
      ack_b = 1'b0;
      nxt();
      rst_n_b = 1'b0;
      nxt();

      // T2: single word, manual ack
      ack_auto = 1'b0;
      send(32'hA5A5_0001);
      chk("t2_req", req_a, 1);
      chk("t2_data", data_a, 32'hA5A5_0001);
      chk("t2_rdy", src_rdy, 0);
      chk("t2_busy", busy, 1);
      src_vld = 1'b0;
      ack_b   = ~ack_b;
      seen    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nxt();
         if (xfer_done) begin
            seen = 1'b1;
            chk("t2_rdy_with_done", src_rdy, 1);
            break;
         end
      end
      chk("t2_done_seen", seen, 1);
      nxt();
      chk("t2_done_pulse", xfer_done, 0);
      chk("t2_idle_rdy", src_rdy, 1);

      // T3: back-to-back words with the receiver model echoing req_a
      ack_tgt  = req_a;
      ack_auto = 1'b1;
      t0 = n_tog;
      d0 = n_done;
      for (int k = 1; k <= 4; k++) send(32'(k));
      src_vld = 1'b0;
      wait_drain(100);
      chk("t3_toggles", n_tog - t0, 4);
      chk("t3_dones", n_done - d0, 4);

      // T4: lost ack -> timeout, late ack ignored, err_clr recovers
      ack_auto = 1'b0;
      nxt();
      d0 = n_done;
      send(32'hDEAD_0004);
      src_vld = 1'b0;
      tk = 0;
      for (int k = 1; k <= 20; k++) begin
         nxt();
         tk = k;
         if (timeout_err) break;
      end
      chk("t4_tmo_cycles", tk, 8);
      done_q.delete();
      chk("t4_rdy", src_rdy, 0);
      chk("t4_busy", busy, 1);
      ack_b = req_a;
      repeat (5) nxt();
      chk("t4_err_sticky", timeout_err, 1);
      chk("t4_rdy_late", src_rdy, 0);
      chk("t4_late_ack", n_done - d0, 0);
      err_clr = 1'b1;
      nxt();
      err_clr = 1'b0;
      chk("t4_err_clr", timeout_err, 0);
      chk("t4_rdy_clr", src_rdy, 1);
      chk("t4_busy_clr", busy, 0);
      t0 = n_tog;
      ack_tgt  = req_a;
      ack_auto = 1'b1;
      send(32'h0000_BEEF);
      src_vld = 1'b0;
      wait_drain(50);
      chk("t4_next_toggle", n_tog - t0, 1);

      // T5: stale ack in IDLE is dropped
      ack_auto = 1'b0;
      nxt();
      d0 = n_done;
      ack_b = ~ack_b;
      repeat (5) nxt();
      chk("t5_no_done", n_done - d0, 0);
      chk("t5_rdy", src_rdy, 1);
      chk("t5_busy", busy, 0);
      send(32'h5555_0005);
      src_vld = 1'b0;
      repeat (4) nxt();
      chk("t5_wait_own", n_done - d0, 0);
      chk("t5_busy_wait", busy, 1);
      ack_b = ~ack_b;
      wait_drain(6);
      chk("t5_done", n_done - d0, 1);

      // T6: asynchronous reset in the middle of WAIT_ACK
      send(32'h6666_0006);
      src_vld = 1'b0;
      nxt();
      nxt();
      @(posedge gated_clka);
      #2;
      rst_n_b = 1'b1;
      #1;
      chk("t6_req", req_a, 0);
      chk("t6_data", data_a, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rdy", src_rdy, 1);
      launch_q.delete();
      done_q.delete();
      ack_b = 1'b0;
      nxt();
      nxt();
      rst_n_b = 1'b0;
      nxt();
      ack_tgt  = 1'b0;
      ack_auto = 1'b1;
      t0 = n_tog;
      d0 = n_done;
      send(32'h7777_0007);
      src_vld = 1'b0;
      wait_drain(50);
      chk("t6_toggle", n_tog - t0, 1);
      chk("t6_done", n_done - d0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
